// File: rtl/rggen_apb_pkg.sv
// rggen_apb_pkg: shared state encoding, status codes and sizing helper for APB initiators
package rggen_apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESPONSE
    } rggen_apb_state_e;

    localparam logic [1:0] RGGEN_APB_OKAY    = 2'b00;
    localparam logic [1:0] RGGEN_APB_SLVERR  = 2'b10;
    localparam logic [1:0] RGGEN_APB_TIMEOUT = 2'b11;

    function automatic int counter_width(int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/rggen_timeout_counter.sv
// rggen_timeout_counter: wait-cycle counter flagging the last allowed cycle; TIMEOUT_CYCLES=0 never expires
module rggen_timeout_counter
    import rggen_apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW   = counter_width(TIMEOUT_CYCLES);
    localparam int LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = clear ? '0 : (enable && TIMEOUT_CYCLES != 0) ? count_q + CW'(1) : count_q;
        expired = (TIMEOUT_CYCLES != 0) && enable && (count_q == CW'(LAST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rggen_apb_requester.sv
// rggen_apb_requester: single-outstanding APB4 initiator with bounded ACCESS-phase wait
module rggen_apb_requester
    import rggen_apb_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_command_valid,
    output logic                      o_command_ready,
    input  logic                      i_write,
    input  logic [ADDRESS_WIDTH-1:0]  i_address,
    input  logic [2:0]                i_pprot,
    input  logic [DATA_WIDTH/8-1:0]   i_strobe,
    input  logic [DATA_WIDTH-1:0]     i_write_data,
    output logic                      o_response_valid,
    input  logic                      i_response_ready,
    output logic [DATA_WIDTH-1:0]     o_read_data,
    output logic [1:0]                o_status,
    output logic [ADDRESS_WIDTH-1:0]  o_paddr,
    output logic [2:0]                o_pprot,
    output logic                      o_psel,
    output logic                      o_penable,
    output logic                      o_pwrite,
    output logic [DATA_WIDTH-1:0]     o_pwdata,
    output logic [DATA_WIDTH/8-1:0]   o_pstrb,
    input  logic                      i_pready,
    input  logic [DATA_WIDTH-1:0]     i_prdata,
    input  logic                      i_pslverr
);

    localparam int SW = DATA_WIDTH / 8;

    rggen_apb_state_e          state_q, state_d;
    logic                      command_ready_q, command_ready_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [ADDRESS_WIDTH-1:0]  paddr_q, paddr_d;
    logic [2:0]                pprot_q, pprot_d;
    logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
    logic [SW-1:0]             pstrb_q, pstrb_d;
    logic                      response_valid_q, response_valid_d;
    logic [DATA_WIDTH-1:0]     read_data_q, read_data_d;
    logic [1:0]                status_q, status_d;
    logic                      expired;

    rggen_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != ACCESS),
        .enable  ((state_q == ACCESS) && !i_pready),
        .expired (expired)
    );

    always_comb begin
        state_d          = state_q;
        command_ready_d  = command_ready_q;
        psel_d           = psel_q;
        penable_d        = penable_q;
        pwrite_d         = pwrite_q;
        paddr_d          = paddr_q;
        pprot_d          = pprot_q;
        pwdata_d         = pwdata_q;
        pstrb_d          = pstrb_q;
        response_valid_d = response_valid_q;
        read_data_d      = read_data_q;
        status_d         = status_q;
        unique case (state_q)
            IDLE: begin
                if (i_command_valid) begin
                    state_d         = SETUP;
                    command_ready_d = 1'b0;
                    psel_d          = 1'b1;
                    pwrite_d        = i_write;
                    paddr_d         = i_address;
                    pprot_d         = i_pprot;
                    pwdata_d        = i_write ? i_write_data : '0;
                    pstrb_d         = i_write ? i_strobe : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // a completion in the expiring cycle takes priority over the timeout
                if (i_pready || expired) begin
                    state_d          = RESPONSE;
                    psel_d           = 1'b0;
                    penable_d        = 1'b0;
                    response_valid_d = 1'b1;
                    status_d         = !i_pready ? RGGEN_APB_TIMEOUT : i_pslverr ? RGGEN_APB_SLVERR : RGGEN_APB_OKAY;
                    read_data_d      = (i_pready && !i_pslverr && !pwrite_q) ? i_prdata : '0;
                end
            end
            RESPONSE: begin
                if (i_response_ready) begin
                    state_d          = IDLE;
                    response_valid_d = 1'b0;
                    command_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            command_ready_q  <= 1'b1;
            psel_q           <= 1'b0;
            penable_q        <= 1'b0;
            pwrite_q         <= 1'b0;
            paddr_q          <= '0;
            pprot_q          <= '0;
            pwdata_q         <= '0;
            pstrb_q          <= '0;
            response_valid_q <= 1'b0;
            read_data_q      <= '0;
            status_q         <= RGGEN_APB_OKAY;
        end else begin
            state_q          <= state_d;
            command_ready_q  <= command_ready_d;
            psel_q           <= psel_d;
            penable_q        <= penable_d;
            pwrite_q         <= pwrite_d;
            paddr_q          <= paddr_d;
            pprot_q          <= pprot_d;
            pwdata_q         <= pwdata_d;
            pstrb_q          <= pstrb_d;
            response_valid_q <= response_valid_d;
            read_data_q      <= read_data_d;
            status_q         <= status_d;
        end
    end

    assign o_command_ready  = command_ready_q;
    assign o_psel           = psel_q;
    assign o_penable        = penable_q;
    assign o_pwrite         = pwrite_q;
    assign o_paddr          = paddr_q;
    assign o_pprot          = pprot_q;
    assign o_pwdata         = pwdata_q;
    assign o_pstrb          = pstrb_q;
    assign o_response_valid = response_valid_q;
    assign o_read_data      = read_data_q;
    assign o_status         = status_q;

endmodule
